// File: rtl/mcs4_timing_pkg.sv
// Shared definitions for the MCS-4 instruction-cycle timing generator:
// subcycle encoding, default subcycle length, refresh row width and
// small helpers for walking and decoding the subcycle sequence.
package mcs4_timing_pkg;

  localparam int unsigned SUBCYCLE_TICKS_DEFAULT = 32'd8;
  localparam int unsigned RFSH_W                 = 32'd3;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  // Successor in the A1..X3 ring; X3 returns to A1.
  function automatic subcycle_e subcycle_next(input subcycle_e sc);
    subcycle_e nxt;
    case (sc)
      SC_A1:   nxt = SC_A2;
      SC_A2:   nxt = SC_A3;
      SC_A3:   nxt = SC_M1;
      SC_M1:   nxt = SC_M2;
      SC_M2:   nxt = SC_X1;
      SC_X1:   nxt = SC_X2;
      SC_X2:   nxt = SC_X3;
      SC_X3:   nxt = SC_A1;
      default: nxt = SC_A1;
    endcase
    return nxt;
  endfunction

  // One-hot level vector, bit 0 = A1 ... bit 7 = X3.
  function automatic logic [7:0] subcycle_onehot(input subcycle_e sc);
    logic [7:0] lv;
    case (sc)
      SC_A1:   lv = 8'h01;
      SC_A2:   lv = 8'h02;
      SC_A3:   lv = 8'h04;
      SC_M1:   lv = 8'h08;
      SC_M2:   lv = 8'h10;
      SC_X1:   lv = 8'h20;
      SC_X2:   lv = 8'h40;
      SC_X3:   lv = 8'h80;
      default: lv = 8'h00;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/mcs4_timing_gen_phase_ctr.sv
// Tick and subcycle counter for the MCS-4 timing generator.
// Exposes the next-state subcycle/run flag so the parent can register
// its level decode on the same edge, plus registered tick-0, mid-tick
// and end-of-cycle strobes aligned with the counter state.
import mcs4_timing_pkg::*;

module mcs4_phase_ctr #(
  parameter int unsigned SUBCYCLE_TICKS = SUBCYCLE_TICKS_DEFAULT
) (
  input  logic      sysclk,
  input  logic      poc_n,
  output logic      run_next,
  output subcycle_e sub_next,
  output logic      tick0_stb,
  output logic      mid_stb,
  output logic      wrap_stb
);

  localparam int unsigned TICK_W = $clog2(SUBCYCLE_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SUBCYCLE_TICKS - 32'd1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SUBCYCLE_TICKS / 32'd2);
  localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};

  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] tick_next_s;
  subcycle_e         sub_r;
  subcycle_e         sub_next_s;
  logic              started_r;
  logic              started_next_s;
  logic              tick0_r;
  logic              mid_r;
  logic              wrap_r;

  // Next tick/subcycle: reset clears, first run edge lands on A1 tick 0.
  always_comb begin
    tick_next_s    = '0;
    sub_next_s     = SC_A1;
    started_next_s = 1'b0;
    if (!poc_n) begin
      tick_next_s    = '0;
      sub_next_s     = SC_A1;
      started_next_s = 1'b0;
    end else if (!started_r) begin
      tick_next_s    = '0;
      sub_next_s     = SC_A1;
      started_next_s = 1'b1;
    end else if (tick_r == TICK_LAST) begin
      tick_next_s    = '0;
      sub_next_s     = subcycle_next(sub_r);
      started_next_s = 1'b1;
    end else begin
      tick_next_s    = tick_r + TICK_ONE;
      sub_next_s     = sub_r;
      started_next_s = 1'b1;
    end
  end

  // Counter state and strobes, all registered from the next state.
  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      tick_r    <= '0;
      sub_r     <= SC_A1;
      started_r <= 1'b0;
      tick0_r   <= 1'b0;
      mid_r     <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      tick_r    <= tick_next_s;
      sub_r     <= sub_next_s;
      started_r <= started_next_s;
      tick0_r   <= started_next_s & (tick_next_s == '0);
      mid_r     <= started_next_s & (tick_next_s == TICK_MID);
      wrap_r    <= started_next_s & (tick_next_s == TICK_LAST) & (sub_next_s == SC_X3);
    end
  end

  assign run_next  = started_next_s;
  assign sub_next  = sub_next_s;
  assign tick0_stb = tick0_r;
  assign mid_stb   = mid_r;
  assign wrap_stb  = wrap_r;

endmodule

// File: rtl/mcs4_timing_gen.sv
// MCS-4 instruction-cycle timing generator: phase enables, subcycle
// levels A1..X3, sync, data-in gate, power-on clear and the scratchpad
// refresh row. Every output comes straight from a flop.
import mcs4_timing_pkg::*;

module mcs4_timing_gen #(
  parameter int unsigned SUBCYCLE_TICKS = SUBCYCLE_TICKS_DEFAULT,
  parameter int unsigned POC_CYCLES     = 32'd1
) (
  input  logic              sysclk,
  input  logic              poc_n,
  output logic              clk1,
  output logic              clk2,
  output logic              a12,
  output logic              a22,
  output logic              a32,
  output logic              m12,
  output logic              m22,
  output logic              x12,
  output logic              x22,
  output logic              x32,
  output logic              sync,
  output logic              gate,
  output logic              poc,
  output logic [RFSH_W-1:0] reg_rfsh
);

  localparam int unsigned PC_W = $clog2(POC_CYCLES + 32'd1);
  localparam logic [PC_W-1:0]   POC_LAST = PC_W'(POC_CYCLES - 32'd1);
  localparam logic [PC_W-1:0]   POC_SAT  = PC_W'(POC_CYCLES);
  localparam logic [PC_W-1:0]   PC_ONE   = PC_W'(32'd1);
  localparam logic [RFSH_W-1:0] RFSH_ONE = {{(RFSH_W-1){1'b0}}, 1'b1};

  logic            run_next_s;
  subcycle_e       sub_next_s;
  logic            tick0_s;
  logic            mid_s;
  logic            wrap_s;
  logic [7:0]      levels_r;
  logic [RFSH_W-1:0] rfsh_r;
  logic            poc_r;
  logic [PC_W-1:0] poc_cnt_r;

  mcs4_phase_ctr #(
    .SUBCYCLE_TICKS(SUBCYCLE_TICKS)
  ) u_phase_ctr (
    .sysclk   (sysclk),
    .poc_n    (poc_n),
    .run_next (run_next_s),
    .sub_next (sub_next_s),
    .tick0_stb(tick0_s),
    .mid_stb  (mid_s),
    .wrap_stb (wrap_s)
  );

  // Subcycle levels: one-hot of the subcycle being entered, zero when idle.
  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      levels_r <= 8'h00;
    end else if (run_next_s) begin
      levels_r <= subcycle_onehot(sub_next_s);
    end else begin
      levels_r <= 8'h00;
    end
  end

  // Refresh row and power-on clear both step on the edge leaving X3.
  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      rfsh_r    <= '0;
      poc_r     <= 1'b1;
      poc_cnt_r <= '0;
    end else if (wrap_s) begin
      rfsh_r <= rfsh_r + RFSH_ONE;
      if (poc_cnt_r == POC_LAST) begin
        poc_r     <= 1'b0;
        poc_cnt_r <= POC_SAT;
      end else if (poc_cnt_r < POC_SAT) begin
        poc_cnt_r <= poc_cnt_r + PC_ONE;
      end else begin
        poc_cnt_r <= poc_cnt_r;
      end
    end else begin
      rfsh_r    <= rfsh_r;
      poc_cnt_r <= poc_cnt_r;
    end
  end

  assign clk1     = tick0_s;
  assign gate     = tick0_s;
  assign clk2     = mid_s;
  assign a12      = levels_r[0];
  assign a22      = levels_r[1];
  assign a32      = levels_r[2];
  assign m12      = levels_r[3];
  assign m22      = levels_r[4];
  assign x12      = levels_r[5];
  assign x22      = levels_r[6];
  assign x32      = levels_r[7];
  assign sync     = levels_r[7];
  assign poc      = poc_r;
  assign reg_rfsh = rfsh_r;

endmodule

// File: tb/tb_mcs4_timing_gen.sv
// Scoreboard bench for mcs4_timing_gen. Three instances run from one
// poc_n: defaults, POC_CYCLES=2, and SUBCYCLE_TICKS=4. The driver
// pushes the expected output word for each edge; the monitor pops and
// compares just after the edge, plus hand-computed constants at key points.
module tb_mcs4_timing_gen;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b0;

  always #5 sysclk = ~sysclk;

  // Packed view: [15:8] levels A1..X3, 7 clk1, 6 clk2, 5 gate, 4 sync, 3 poc, [2:0] rfsh
  wire [15:0] o0;
  wire [15:0] o1;
  wire [15:0] o2;

  mcs4_timing_gen u_dut_def (
    .sysclk(sysclk), .poc_n(poc_n),
    .clk1(o0[7]), .clk2(o0[6]),
    .a12(o0[8]), .a22(o0[9]), .a32(o0[10]), .m12(o0[11]),
    .m22(o0[12]), .x12(o0[13]), .x22(o0[14]), .x32(o0[15]),
    .sync(o0[4]), .gate(o0[5]), .poc(o0[3]), .reg_rfsh(o0[2:0])
  );

  mcs4_timing_gen #(.SUBCYCLE_TICKS(8), .POC_CYCLES(2)) u_dut_poc2 (
    .sysclk(sysclk), .poc_n(poc_n),
    .clk1(o1[7]), .clk2(o1[6]),
    .a12(o1[8]), .a22(o1[9]), .a32(o1[10]), .m12(o1[11]),
    .m22(o1[12]), .x12(o1[13]), .x22(o1[14]), .x32(o1[15]),
    .sync(o1[4]), .gate(o1[5]), .poc(o1[3]), .reg_rfsh(o1[2:0])
  );

  mcs4_timing_gen #(.SUBCYCLE_TICKS(4), .POC_CYCLES(1)) u_dut_t4 (
    .sysclk(sysclk), .poc_n(poc_n),
    .clk1(o2[7]), .clk2(o2[6]),
    .a12(o2[8]), .a22(o2[9]), .a32(o2[10]), .m12(o2[11]),
    .m22(o2[12]), .x12(o2[13]), .x22(o2[14]), .x32(o2[15]),
    .sync(o2[4]), .gate(o2[5]), .poc(o2[3]), .reg_rfsh(o2[2:0])
  );

  typedef struct {
    int          pos;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int pos      = -1;

  // Expected word for an edge 'p' edges after release (-1 = in reset).
  function automatic logic [15:0] model(input int p, input int t, input int pc);
    logic [15:0] v;
    int tick, sub, cyc;
    v = 16'h0000;
    if (p < 0) begin
      v[3] = 1'b1;
    end else begin
      tick = p % t;
      sub  = (p / t) % 8;
      cyc  = p / (8 * t);
      v[8 + sub] = 1'b1;
      v[7] = (tick == 0);
      v[6] = (tick == t / 2);
      v[5] = (tick == 0);
      v[4] = (sub == 7);
      v[3] = (cyc < pc);
      v[2:0] = 3'(cyc % 8);
    end
    return v;
  endfunction

  task automatic chk(input string name, input int p, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s pos=%0d actual=%h required=%h", name, p, act, exp);
    end
  endtask

  // Drive one edge's worth of poc_n and queue what that edge must produce.
  task automatic step(input logic rn);
    exp_t e;
    poc_n = rn;
    pos   = rn ? pos + 1 : -1;
    e.pos = pos;
    e.e0  = model(pos, 8, 1);
    e.e1  = model(pos, 8, 2);
    e.e2  = model(pos, 4, 1);
    q.push_back(e);
    @(posedge sysclk);
    #2;
  endtask

  // Monitor: every edge presents a new output word; compare just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge sysclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("def_word",  e.pos, o0, e.e0);
        chk("poc2_word", e.pos, o1, e.e1);
        chk("t4_word",   e.pos, o2, e.e2);
        chk("def_clk_overlap", e.pos, {15'h0000, o0[7] & o0[6]}, 16'h0000);
        chk("t4_clk_overlap",  e.pos, {15'h0000, o2[7] & o2[6]}, 16'h0000);
        case (e.pos)
          -1: begin
            chk("rst_def",  e.pos, o0, 16'h0008);
            chk("rst_poc2", e.pos, o1, 16'h0008);
            chk("rst_t4",   e.pos, o2, 16'h0008);
          end
          0: begin
            chk("rel_def", e.pos, o0, 16'h01A8);
            chk("rel_t4",  e.pos, o2, 16'h01A8);
          end
          2:   chk("t4_clk2_tick2",    e.pos, o2, 16'h0148);
          4:   chk("def_clk2_tick4",   e.pos, o0, 16'h0148);
          32:  chk("t4_cycle32",       e.pos, o2, 16'h01A1);
          56:  chk("def_sync_rise",    e.pos, o0, 16'h80B8);
          63:  chk("def_sync_last",    e.pos, o0, 16'h8018);
          64:  chk("def_wrap_poc",     e.pos, o0, 16'h01A1);
          127: chk("poc2_before_fall", e.pos, o1, 16'h8019);
          128: chk("poc2_fall",        e.pos, o1, 16'h01A2);
          355: chk("def_m2_tick3",     e.pos, o0, 16'h1005);
          512: chk("def_rfsh_wrap",    e.pos, o0, 16'h01A0);
          default: ;
        endcase
      end
    end
  end

  // Stimulus: reset hold, long run, mid-cycle reset, random run/reset mix.
  initial begin
    int len;
    repeat (5) step(1'b0);
    repeat (521) step(1'b1);
    step(1'b0);
    repeat (356) step(1'b1);
    step(1'b0);
    repeat (70) step(1'b1);
    for (int i = 0; i < 1000; i++) begin
      len = $urandom_range(40, 1);
      repeat (len) step(1'b1);
      len = $urandom_range(2, 1);
      repeat (len) step(1'b0);
    end
    repeat (2) @(posedge sysclk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
